alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_serial_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: streams operand bits LSB first through an external
// 1-bit ALU slice, collects the result and carry, and returns one response.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_z,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [1:0]       op_reg;
    logic [IW-1:0]    idx;
    logic             carry_reg;

    logic accept;
    logic retire;
    logic last_bit;

    assign accept   = (state == S_IDLE) && req_valid;
    assign retire   = (state == S_DONE) && rsp_ready;
    assign last_bit = (idx == IW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output is given a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept)   state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  if (retire)   state_next = S_IDLE;
            default:               state_next = S_IDLE;
        endcase
    end

    // NOTE: these are a handful of flops, not a memory array, so they all take
    // the asynchronous reset and no stale operand survives an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            idx        <= '0;
            carry_reg  <= 1'b0;
        end else if (accept) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            op_reg     <= req_op;
            result_reg <= '0;
            idx        <= '0;
            // Subtraction is A + ~B + 1, so the first carry-in is the +1.
            carry_reg  <= (req_op == OP_SUB);
        end else if (state == S_RUN) begin
            result_reg[idx] <= slice_z;
            if (op_reg[1]) begin
                carry_reg <= slice_cout;
            end
            if (!last_bit) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = 1'b0;
        rsp_z     = '0;
        rsp_cout  = 1'b0;
        rsp_zero  = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 2'b00;
        case (state)
            S_RUN: begin
                slice_a   = a_reg[idx];
                slice_b   = b_reg[idx];
                slice_cin = carry_reg;
                slice_op  = op_reg;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_z     = result_reg;
                rsp_cout  = op_reg[1] & carry_reg;
                rsp_zero  = (result_reg == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: behavioural slice, directed and random operations
// checked against whole-word arithmetic, backpressure and mid-run reset.
module tb_alu_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic [1:0]       slice_op;
    logic             slice_z;
    logic             slice_cout;

    int n_vec = 0;
    int n_err = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_z    (slice_z),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit slice.
    always_comb begin
        logic [1:0] sum;
        sum        = 2'b00;
        slice_z    = 1'b0;
        slice_cout = 1'b0;
        case (slice_op)
            2'b00: slice_z = ~(slice_a & slice_b);
            2'b01: slice_z = ~(slice_a | slice_b);
            2'b10: begin
                sum = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
                {slice_cout, slice_z} = sum;
            end
            default: begin
                sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
                {slice_cout, slice_z} = sum;
            end
        endcase
    end

    // Word-level reference: returns {cout, z}.
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, b, input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, ~(a & b)};
            2'b01:   return {1'b0, ~(a | b)};
            2'b10:   return {1'b0, a} + {1'b0, b};
            default: return {1'b0, a} + {1'b0, ~b} + 1'b1;
        endcase
    endfunction

    // Carry entering bit i, from the sum of the low i bits.
    function automatic logic carry_into(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input int i);
        logic [63:0] m, s;
        if (op[1] == 1'b0) return 1'b0;
        m = (64'd1 << i) - 64'd1;
        if (op == 2'b10) s = (64'(a) & m) + (64'(b) & m);
        else             s = (64'(a) & m) + (64'(~b) & m) + 64'd1;
        return s[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_slices_idle(input string tag);
        check({tag, "_slice_a"},   32'(slice_a),   0);
        check({tag, "_slice_b"},   32'(slice_b),   0);
        check({tag, "_slice_cin"}, 32'(slice_cin), 0);
        check({tag, "_slice_op"},  32'(slice_op),  0);
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic [WIDTH-1:0] a, b, input logic [1:0] op, input int hold);
        logic [WIDTH:0] exp;
        exp       = ref_op(a, b, op);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        check("req_ready_idle", 32'(req_ready), 1);
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b0;
                req_a     = WIDTH'($urandom);
                req_b     = WIDTH'($urandom);
                req_op    = 2'($urandom);
            end
            check($sformatf("run%0d_rsp_valid", i), 32'(rsp_valid), 0);
            check($sformatf("run%0d_req_ready", i), 32'(req_ready), 0);
            check($sformatf("run%0d_slice_a", i),   32'(slice_a),   32'(a[i]));
            check($sformatf("run%0d_slice_b", i),   32'(slice_b),   32'(b[i]));
            check($sformatf("run%0d_slice_op", i),  32'(slice_op),  32'(op));
            check($sformatf("run%0d_slice_cin", i), 32'(slice_cin), 32'(carry_into(a, b, op, i)));
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check("done_rsp_valid", 32'(rsp_valid), 1);
            check("done_rsp_z",     32'(rsp_z),     32'(exp[WIDTH-1:0]));
            check("done_rsp_cout",  32'(rsp_cout),  32'(exp[WIDTH]));
            check("done_rsp_zero",  32'(rsp_zero),  32'(exp[WIDTH-1:0] == '0));
            check("done_req_ready", 32'(req_ready), 0);
            check_slices_idle("done");
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("retire_rsp_valid", 32'(rsp_valid), 0);
        check("retire_req_ready", 32'(req_ready), 1);
        check("retire_rsp_z",     32'(rsp_z),     0);
        check("retire_rsp_zero",  32'(rsp_zero),  0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 2'b00;
        rsp_ready = 1'b0;
        #2;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_z",     32'(rsp_z),     0);
        check("rst_rsp_cout",  32'(rsp_cout),  0);
        check("rst_rsp_zero",  32'(rsp_zero),  0);
        check_slices_idle("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h3C, 8'h05, 2'b10, 0);
        run_op(8'hFF, 8'h01, 2'b10, 0);
        run_op(8'h05, 8'h05, 2'b11, 1);
        run_op(8'h03, 8'h05, 2'b11, 0);
        run_op(8'hF0, 8'hCC, 2'b00, 0);
        run_op(8'hF0, 8'h0C, 2'b01, 0);
        // Five stalled cycles with a request pending, then back-to-back issue.
        run_op(8'hA5, 8'h5A, 2'b10, 5);
        run_op(8'h80, 8'h01, 2'b11, 0);

        // Reset with idx at 4 aborts the operation immediately.
        req_a     = 8'h77;
        req_b     = 8'h19;
        req_op    = 2'b10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_abort_slice_a", 32'(slice_a), 32'(1'b1));
        check("pre_abort_slice_b", 32'(slice_b), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 1);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        check_slices_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < WIDTH + 2; k++) begin
            @(negedge clk);
            check("post_abort_rsp_valid", 32'(rsp_valid), 0);
            check("post_abort_req_ready", 32'(req_ready), 1);
        end
        rsp_ready = 1'b0;
        run_op(8'h10, 8'h20, 2'b10, 0);

        for (int r = 0; r < 20; r++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
